// File: rtl/svf_pkg.sv
// Shared definitions for the multichannel state-variable filter: FSM states,
// register map and the saturating-arithmetic helper.
package svf_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      LOW_ISS,
      LOW_WAIT,
      HIGH_ISS,
      HIGH_WAIT,
      BAND_ISS,
      BAND_WAIT,
      NEXT,
      COMMIT
   } svf_state_t;

   localparam logic [4:0] REG_FC_LO    = 5'h15;
   localparam logic [4:0] REG_FC_HI    = 5'h16;
   localparam logic [4:0] REG_RES_FILT = 5'h17;

   // Resonance coefficient at res = 0: 3*2^(cw-2) - 1 (0xBFFF at cw = 16).
   function automatic logic [31:0] res_base(input int unsigned cw);
      return (32'd3 << (cw - 2)) - 32'd1;
   endfunction

   // Clamp a signed value to the range of a w-bit signed number (w <= 30).
   function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                              input int unsigned w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/svf_mac.sv
// Registered signed x unsigned multiplier with MUL_LAT pipeline stages;
// maps onto a single SB_MAC16 at 16x16.
module svf_mac #(
   parameter int unsigned DW      = 16,
   parameter int unsigned CW      = 16,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic                        clk,
   input  logic signed [DW-1:0]        a,
   input  logic        [CW-1:0]        b,
   output logic signed [DW+CW-1:0]     p
);

   logic signed [DW+CW:0]   prod;
   logic signed [DW+CW-1:0] pipe [MUL_LAT];

   // The zero-extended coefficient keeps the product inside DW+CW signed bits.
   assign prod = a * $signed({1'b0, b});

   always_ff @(posedge clk) begin
      pipe[0] <= (DW+CW)'(prod);
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign p = pipe[MUL_LAT-1];

endmodule

// File: rtl/svf_filter_mc.sv
// Time-multiplexed CHANNELS-way state-variable filter sharing one multiplier.
// Optional macro SVF_SLEW_EN: slew-limit the working cutoff coefficient.
module svf_filter_mc
   import svf_pkg::*;
#(
   parameter int unsigned DW        = 16,
   parameter int unsigned CW        = 16,
   parameter int unsigned CHANNELS  = 3,
   parameter int unsigned MUL_LAT   = 2,
   parameter int unsigned SLEW_STEP = 64,
   localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clkEn,
   input  logic [CHANNELS*DW-1:0] iIn,
   input  logic                   WR,
   input  logic [CHW-1:0]         CH,
   input  logic [4:0]             ADDR,
   input  logic [7:0]             DATA,
   output logic [CHANNELS*DW-1:0] oLP,
   output logic [CHANNELS*DW-1:0] oBP,
   output logic [CHANNELS*DW-1:0] oHP,
   output logic                   oValid,
   output logic                   oBusy
);

   localparam int unsigned CNTW = $clog2(MUL_LAT + 1);

   svf_state_t state, state_n;

   logic [CHW-1:0]       c;
   logic [CNTW-1:0]      cnt;
   logic [10:0]          freq_r [CHANNELS];
   logic [3:0]           res_r  [CHANNELS];
   logic [10:0]          freq_n [CHANNELS];
   logic [3:0]           res_n  [CHANNELS];
   logic [CW-1:0]        cut_t  [CHANNELS];
   logic [CW-1:0]        res_t  [CHANNELS];
   logic [CW-1:0]        cut_s  [CHANNELS];
   logic [CW-1:0]        cut_w  [CHANNELS];
   logic [CW-1:0]        res_w  [CHANNELS];
   logic signed [DW-1:0] in_l   [CHANNELS];
   logic signed [DW-1:0] low    [CHANNELS];
   logic signed [DW-1:0] band   [CHANNELS];
   logic signed [DW-1:0] high   [CHANNELS];

   logic signed [DW-1:0]    mul_a;
   logic        [CW-1:0]    mul_b;
   logic signed [DW+CW-1:0] prod;
   logic signed [DW-1:0]    p;
   logic signed [DW+1:0]    sum_low, sum_high, sum_band;
   logic signed [DW-1:0]    low_sat, high_sat, band_sat;

   // Register writes are folded in combinationally so that a write coinciding
   // with a sample strobe is already visible to the coefficients latched then.
   always_comb begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         freq_n[k] = freq_r[k];
         res_n[k]  = res_r[k];
         if (WR && (32'(CH) == k)) begin
            case (ADDR)
               REG_FC_LO:    freq_n[k][2:0]  = DATA[2:0];
               REG_FC_HI:    freq_n[k][10:3] = DATA;
               REG_RES_FILT: res_n[k]        = DATA[7:4];
               default:      ;
            endcase
         end
         cut_t[k] = CW'(freq_n[k]) << (CW - 14);
         res_t[k] = CW'(res_base(CW)) - (CW'(res_n[k]) << (CW - 5));
`ifdef SVF_SLEW_EN
         if (cut_t[k] > cut_w[k])
            cut_s[k] = ((cut_t[k] - cut_w[k]) > CW'(SLEW_STEP)) ?
                       cut_w[k] + CW'(SLEW_STEP) : cut_t[k];
         else
            cut_s[k] = ((cut_w[k] - cut_t[k]) > CW'(SLEW_STEP)) ?
                       cut_w[k] - CW'(SLEW_STEP) : cut_t[k];
`else
         cut_s[k] = cut_t[k];
`endif
      end
   end

   always_comb begin
      mul_a = band[c];
      mul_b = cut_w[c];
      if (state == HIGH_ISS) mul_b = res_w[c];
      if (state == BAND_ISS) mul_a = high[c];
   end

   svf_mac #(
      .DW      (DW),
      .CW      (CW),
      .MUL_LAT (MUL_LAT)
   ) u_mac (
      .clk (clk),
      .a   (mul_a),
      .b   (mul_b),
      .p   (prod)
   );

   always_comb begin
      p        = DW'(prod >>> CW);
      sum_low  = (DW+2)'(low[c]) + (DW+2)'(p);
      sum_high = (DW+2)'(in_l[c]) - (DW+2)'(low[c]) - (DW+2)'(p);
      sum_band = (DW+2)'(band[c]) + (DW+2)'(p);
      low_sat  = DW'(sat(32'(sum_low), DW));
      high_sat = DW'(sat(32'(sum_high), DW));
      band_sat = DW'(sat(32'(sum_band), DW));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // BAND_WAIT is one cycle shorter than the other waits: the band update
   // lands in NEXT, which is the cycle its product becomes valid.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (clkEn) state_n = START;
         START:     state_n = LOW_ISS;
         LOW_ISS:   state_n = LOW_WAIT;
         LOW_WAIT:  if (32'(cnt) == MUL_LAT - 1) state_n = HIGH_ISS;
         HIGH_ISS:  state_n = HIGH_WAIT;
         HIGH_WAIT: if (32'(cnt) == MUL_LAT - 1) state_n = BAND_ISS;
         BAND_ISS:  state_n = (MUL_LAT == 1) ? NEXT : BAND_WAIT;
         BAND_WAIT: if (32'(cnt) == MUL_LAT - 2) state_n = NEXT;
         NEXT:      state_n = (32'(c) == CHANNELS - 1) ? COMMIT : LOW_ISS;
         COMMIT:    state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c      <= '0;
         cnt    <= '0;
         oLP    <= '0;
         oBP    <= '0;
         oHP    <= '0;
         oValid <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            freq_r[k] <= '0;
            res_r[k]  <= '0;
            cut_w[k]  <= '0;
            res_w[k]  <= '0;
            in_l[k]   <= '0;
            low[k]    <= '0;
            band[k]   <= '0;
            high[k]   <= '0;
         end
      end else begin
         oValid <= 1'b0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            freq_r[k] <= freq_n[k];
            res_r[k]  <= res_n[k];
         end
         case (state)
            IDLE: begin
               if (clkEn) begin
                  c <= '0;
                  for (int unsigned k = 0; k < CHANNELS; k++) begin
                     in_l[k]  <= iIn[k*DW +: DW];
                     cut_w[k] <= cut_s[k];
                     res_w[k] <= res_t[k];
                  end
               end
            end
            LOW_ISS, HIGH_ISS, BAND_ISS: cnt <= '0;
            LOW_WAIT: begin
               cnt <= cnt + 1'b1;
               if (32'(cnt) == MUL_LAT - 1) low[c] <= low_sat;
            end
            HIGH_WAIT: begin
               cnt <= cnt + 1'b1;
               if (32'(cnt) == MUL_LAT - 1) high[c] <= high_sat;
            end
            BAND_WAIT: cnt <= cnt + 1'b1;
            NEXT: begin
               band[c] <= band_sat;
               c       <= c + 1'b1;
            end
            COMMIT: begin
               oValid <= 1'b1;
               for (int unsigned k = 0; k < CHANNELS; k++) begin
                  oLP[k*DW +: DW] <= low[k];
                  oBP[k*DW +: DW] <= band[k];
                  oHP[k*DW +: DW] <= high[k];
               end
            end
            default: ;
         endcase
      end
   end

   assign oBusy = (state != IDLE);

endmodule

// File: tb/tb_svf_filter_mc.sv
// Self-checking bench for svf_filter_mc against a per-sample arithmetic model
// of the three-channel filter (default build, SVF_SLEW_EN undefined).
module tb_svf_filter_mc;

   localparam int DW      = 16;
   localparam int CW      = 16;
   localparam int NCH     = 3;
   localparam int LAT     = 2;
   localparam int EXP_LAT = NCH * 3 * (LAT + 1) + 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               clkEn = 1'b0;
   logic [NCH*DW-1:0]  iIn = '0;
   logic               WR = 1'b0;
   logic [1:0]         CH = '0;
   logic [4:0]         ADDR = '0;
   logic [7:0]         DATA = '0;
   logic [NCH*DW-1:0]  oLP, oBP, oHP;
   logic               oValid, oBusy;

   int n_cmp = 0;
   int n_bad = 0;

   longint m_low [NCH];
   longint m_band[NCH];
   longint m_high[NCH];
   int     m_freq[NCH];
   int     m_res [NCH];
   longint s_cut [NCH];
   longint s_res [NCH];
   longint s_in  [NCH];

   always #5 clk = ~clk;

   svf_filter_mc #(
      .DW        (DW),
      .CW        (CW),
      .CHANNELS  (NCH),
      .MUL_LAT   (LAT),
      .SLEW_STEP (64)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .clkEn  (clkEn),
      .iIn    (iIn),
      .WR     (WR),
      .CH     (CH),
      .ADDR   (ADDR),
      .DATA   (DATA),
      .oLP    (oLP),
      .oBP    (oBP),
      .oHP    (oHP),
      .oValid (oValid),
      .oBusy  (oBusy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint clamp(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         m_low[k] = 0; m_band[k] = 0; m_high[k] = 0;
         m_freq[k] = 0; m_res[k] = 0;
      end
   endtask

   task automatic model_write(input int ch, input logic [4:0] a, input logic [7:0] d);
      if (ch < NCH) begin
         case (a)
            5'h15: m_freq[ch] = (m_freq[ch] & 32'h7F8) | int'(d[2:0]);
            5'h16: m_freq[ch] = (m_freq[ch] & 32'h007) | (int'(d) << 3);
            5'h17: m_res[ch]  = int'(d[7:4]);
            default: ;
         endcase
      end
   endtask

   task automatic snapshot();
      for (int k = 0; k < NCH; k++) begin
         s_cut[k] = longint'(m_freq[k]) << 2;
         s_res[k] = 64'hBFFF - (longint'(m_res[k]) << 11);
         s_in[k]  = longint'($signed(iIn[k*DW +: DW]));
      end
   endtask

   // One sample of the filter, channel by channel, from the snapshot.
   task automatic model_apply();
      longint p;
      for (int k = 0; k < NCH; k++) begin
         p = (m_band[k] * s_cut[k]) >>> CW;
         m_low[k] = clamp(m_low[k] + p);
         p = (m_band[k] * s_res[k]) >>> CW;
         m_high[k] = clamp(s_in[k] - m_low[k] - p);
         p = (m_high[k] * s_cut[k]) >>> CW;
         m_band[k] = clamp(m_band[k] + p);
      end
   endtask

   function automatic logic [3*NCH*DW-1:0] exp_all();
      logic [NCH*DW-1:0] lp, bp, hp;
      for (int k = 0; k < NCH; k++) begin
         lp[k*DW +: DW] = m_low[k][DW-1:0];
         bp[k*DW +: DW] = m_band[k][DW-1:0];
         hp[k*DW +: DW] = m_high[k][DW-1:0];
      end
      return {lp, bp, hp};
   endfunction

   task automatic set_reg(input int ch, input logic [4:0] a, input logic [7:0] d);
      WR = 1'b1; CH = 2'(ch); ADDR = a; DATA = d;
      model_write(ch, a, d);
      tick();
      WR = 1'b0;
   endtask

   task automatic start_sample();
      snapshot();
      clkEn = 1'b1;
      tick();
      clkEn = 1'b0;
   endtask

   // Latency counts from the cycle clkEn is high to the cycle oValid is high.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (oValid) begin
            lat = i + 1;
            break;
         end
      end
   endtask

   task automatic random_inputs();
      for (int k = 0; k < NCH; k++) iIn[k*DW +: DW] = 16'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      n_cmp++;
      if ({oLP, oBP, oHP} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got %h exp 0", {oLP, oBP, oHP});
      end
      n_cmp++;
      if ({oValid, oBusy} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_flags got %b exp 00", {oValid, oBusy});
      end
   endtask

   task automatic test_dc_latency();
      int lat;
      for (int k = 0; k < NCH; k++) iIn[k*DW +: DW] = 16'h4000;
      start_sample();
      n_cmp++;
      if (oBusy !== 1'b1) begin
         n_bad++;
         $display("FAIL busy_after_start got %b exp 1", oBusy);
      end
      wait_valid(lat);
      model_apply();
      n_cmp++;
      if (lat != EXP_LAT) begin
         n_bad++;
         $display("FAIL latency got %0d exp %0d", lat, EXP_LAT);
      end
      n_cmp++;
      if ({oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL dc_outputs got %h exp %h", {oLP, oBP, oHP}, exp_all());
      end
      n_cmp++;
      if (oBusy !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_at_valid got %b exp 0", oBusy);
      end
      tick();
      n_cmp++;
      if (oValid !== 1'b0) begin
         n_bad++;
         $display("FAIL valid_one_cycle got %b exp 0", oValid);
      end
   endtask

   task automatic test_saturation();
      int lat;
      set_reg(1, 5'h16, 8'hFF);
      set_reg(1, 5'h15, 8'h07);
      for (int k = 0; k < NCH; k++) iIn[k*DW +: DW] = 16'h7FFF;
      for (int s = 0; s < 200; s++) begin
         start_sample();
         wait_valid(lat);
         model_apply();
         n_cmp++;
         if (lat != EXP_LAT || {oLP, oBP, oHP} !== exp_all()) begin
            n_bad++;
            $display("FAIL sat_sample%0d lat %0d got %h exp %h", s, lat,
                     {oLP, oBP, oHP}, exp_all());
         end
      end
      n_cmp++;
      if ({oLP[0 +: DW], oLP[2*DW +: DW]} !== '0) begin
         n_bad++;
         $display("FAIL sat_idle_lp got %h exp 0", {oLP[0 +: DW], oLP[2*DW +: DW]});
      end
   endtask

   task automatic test_random();
      int lat;
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k <= NCH; k++) begin
            set_reg(k, 5'h16, 8'($urandom));
            set_reg(k, 5'h15, 8'($urandom));
            set_reg(k, 5'h17, 8'($urandom));
            set_reg(k, 5'h14, 8'($urandom));
         end
         for (int s = 0; s < 4; s++) begin
            random_inputs();
            start_sample();
            wait_valid(lat);
            model_apply();
            n_cmp++;
            if ({oLP, oBP, oHP} !== exp_all()) begin
               n_bad++;
               $display("FAIL random_r%0d_s%0d got %h exp %h", r, s,
                        {oLP, oBP, oHP}, exp_all());
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int nvalid = 0;
      random_inputs();
      start_sample();
      repeat (4) tick();
      iIn = ~iIn;
      clkEn = 1'b1;
      tick();
      clkEn = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (oValid) nvalid++;
         tick();
      end
      model_apply();
      n_cmp++;
      if (nvalid != 1) begin
         n_bad++;
         $display("FAIL b2b_valid_count got %0d exp 1", nvalid);
      end
      n_cmp++;
      if ({oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL b2b_outputs got %h exp %h", {oLP, oBP, oHP}, exp_all());
      end
   endtask

   task automatic test_write_busy();
      int lat;
      set_reg(0, 5'h16, 8'h74);
      set_reg(0, 5'h15, 8'h05);
      random_inputs();
      start_sample();
      wait_valid(lat);
      model_apply();
      random_inputs();
      start_sample();
      tick();
      set_reg(0, 5'h16, 8'h20);
      set_reg(0, 5'h15, 8'h00);
      wait_valid(lat);
      model_apply();
      n_cmp++;
      if ({oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL busy_write_old got %h exp %h", {oLP, oBP, oHP}, exp_all());
      end
      start_sample();
      wait_valid(lat);
      model_apply();
      n_cmp++;
      if (s_cut[0] != 64'h400 || {oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL busy_write_new got %h exp %h", {oLP, oBP, oHP}, exp_all());
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int nvalid = 0;
      random_inputs();
      start_sample();
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      n_cmp++;
      if ({oLP, oBP, oHP, oValid, oBusy} !== '0) begin
         n_bad++;
         $display("FAIL midreset_state got %h exp 0", {oLP, oBP, oHP, oValid, oBusy});
      end
      for (int i = 0; i < 40; i++) begin
         if (oValid) nvalid++;
         tick();
      end
      n_cmp++;
      if (nvalid != 0) begin
         n_bad++;
         $display("FAIL midreset_valid got %0d exp 0", nvalid);
      end
      set_reg(2, 5'h16, 8'h3C);
      set_reg(2, 5'h17, 8'hA0);
      random_inputs();
      start_sample();
      wait_valid(lat);
      model_apply();
      n_cmp++;
      if (lat != EXP_LAT || {oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL midreset_resume lat %0d got %h exp %h", lat,
                  {oLP, oBP, oHP}, exp_all());
      end
   endtask

   task automatic test_wr_with_clken();
      int lat;
      random_inputs();
      start_sample();
      wait_valid(lat);
      model_apply();
      WR = 1'b1; CH = 2'd2; ADDR = 5'h16; DATA = 8'hE1;
      model_write(2, 5'h16, 8'hE1);
      random_inputs();
      snapshot();
      clkEn = 1'b1;
      tick();
      clkEn = 1'b0;
      WR = 1'b0;
      wait_valid(lat);
      model_apply();
      n_cmp++;
      if ({oLP, oBP, oHP} !== exp_all()) begin
         n_bad++;
         $display("FAIL wr_with_clken got %h exp %h", {oLP, oBP, oHP}, exp_all());
      end
   endtask

   initial begin
      test_reset();
      test_dc_latency();
      test_saturation();
      test_random();
      test_back_to_back();
      test_write_busy();
      test_reset_mid();
      test_wr_with_clken();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/svf_filter_mc.md
Name: svf_filter_mc

Overview:
- Parametrised, time-multiplexed successor to the single-voice SID state-variable filter.
- Processes CHANNELS independent SVFs per sample strobe through one shared signed×unsigned multiplier.
- Uses saturating arithmetic and commits LP/BP/HP for all channels in the same cycle, so mode sums are aligned.
- Sits between voice mixer and output DAC path; configured through the SID register bus with a channel select.

Parameters:
- DW, 16: audio sample width, signed.
- CW, 16: coefficient width, unsigned, must be >= 14.
- CHANNELS, 3: number of independent filter channels, >= 1.
- MUL_LAT, 2: shared multiplier pipeline latency in cycles, >= 1.
- SLEW_STEP, 64: max cutoff-coefficient change per sample; used only with SVF_SLEW_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clkEn  in  1  sample strobe, one-cycle pulse
- iIn  in  CHANNELS*DW  per-channel signed input; channel k at bits [k*DW +: DW]
- WR  in  1  register write strobe
- CH  in  max(1,$clog2(CHANNELS))  channel target of the write
- ADDR  in  5  register address
- DATA  in  8  register data
- oLP  out  CHANNELS*DW  low-pass outputs, same packing as iIn
- oBP  out  CHANNELS*DW  band-pass outputs
- oHP  out  CHANNELS*DW  high-pass outputs
- oValid  out  1  one-cycle pulse when outputs update
- oBusy  out  1  high while a sample is in progress

Interface decision: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset: all low/band/high state, oLP/oBP/oHP, oValid and oBusy go to 0. Register banks go to 0. FSM goes to IDLE. Pipeline contents are discarded.
- Reset mid-sample aborts the sample: no commit, no oValid.
- Registers, per channel CH, on WR:
  - 0x15 writes freq[2:0] = DATA[2:0].
  - 0x16 writes freq[10:3] = DATA.
  - 0x17 writes res = DATA[7:4].
  - Other addresses are ignored. CH >= CHANNELS is ignored.
- Coefficients:
  - cutCoef = freq << (CW-14).
  - resCoef = (3·2^(CW-2) - 1) - (res << (CW-5)). At CW=16 this is 0xBFFF - (res<<11).
- Coefficient latching: targets are latched into working coefficients only when a sample starts. Writes while oBusy is high take effect next sample.
- FSM states: IDLE, START, LOW_ISS, LOW_WAIT, HIGH_ISS, HIGH_WAIT, BAND_ISS, BAND_WAIT, NEXT, COMMIT.
  - IDLE + clkEn: latch iIn and coefficients, channel index c = 0, go to START, oBusy = 1.
  - START -> LOW_ISS.
  - LOW_ISS: issue band[c]×cut, wait MUL_LAT cycles. Then low[c] = sat(low[c] + p).
  - HIGH_ISS: issue band[c]×res. Then high[c] = sat(in[c] - low[c] - p).
  - BAND_ISS: issue high[c]×cut, using the new high. Then band[c] = sat(band[c] + p).
  - NEXT: c+1, or COMMIT when c == CHANNELS-1.
  - COMMIT: copy all state to outputs, oValid = 1 for one cycle, oBusy = 0, go to IDLE.
- Latency: clkEn to oValid takes CHANNELS·3·(MUL_LAT+1) + 3 cycles. With the defaults that is 30.
- clkEn while oBusy is high is ignored; no queueing.
- Arithmetic:
  - Product is DW+CW bits wide; p = product[DW+CW-1:CW].
  - Sums are formed at DW+2 bits and clamped to [-2^(DW-1), 2^(DW-1)-1].
- Simultaneous WR and clkEn in IDLE: the write is applied first, so it is visible in this sample.

Optional Feature:
- Macro: SVF_SLEW_EN.
- With the macro: at each sample start, each channel's working cutCoef moves toward its target by at most SLEW_STEP, landing exactly on the target. resCoef is still immediate.
- Without the macro: working cutCoef equals the target at each sample start.

Decomposition:
- Package svf_pkg holds:
  - FSM state enum.
  - Register address constants 0x15/0x16/0x17.
  - Resonance base constant.
  - Saturate function sat(x, DW).
- Sub-module svf_mac: registered signed×unsigned DW×CW multiplier with MUL_LAT pipeline stages, maps to SB_MAC16 at 16×16.

Test Plan:
1. Reset; freq=0, res=0 on all channels; iIn=0x4000 on all; one clkEn -> oValid exactly 30 cycles later. Per channel LP=0, BP=0, HP=0x4000.
2. Channel 1 only: freq=0x7FF, res=0; DC 0x7FFF on all channels for 200 samples -> ch0/ch2 LP stay 0. Ch1 LP/BP/HP never leave [-0x8000, 0x7FFF] and show no sign wrap on consecutive samples.
3. clkEn pulsed again 5 cycles after start -> single oValid; state equals a one-sample reference model.
4. Write freq=0x100 to ch0 while oBusy is high -> current sample uses the old coefficient, next sample uses cutCoef=0x400.
5. rst asserted 10 cycles after clkEn -> next cycle all outputs 0, oBusy=0, no oValid. The next clkEn completes normally.
6. SVF_SLEW_EN set: freq 0 -> 0x7FF (target 0x1FFC) -> working cutCoef = 64·n after sample n, reaching 0x1FFC at sample 128. Without the macro, 0x1FFC at sample 1.
